trap_sequencer: RTL

- CSR-access initiator that drives the machine-mode CSR file's access port (addr/wdata/we/re/rdata) when the core takes a trap or executes MRET.
- On trap entry: saves state into MSTATUS/MEPC/MCAUSE/MTVAL, reads MTVEC and emits a fetch redirect with the new privilege level.
- On MRET: restores MSTATUS, reads MEPC and emits the return redirect.
- Sits between the pipeline's exception/interrupt logic and the CSR file; owns the CSR port whenever busy.

---
 rtl/trap_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: owns the CSR access port while a
// trap or return is in flight and emits a single fetch redirect at the end.
module trap_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CSR_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_req,
  input  logic                  trap_is_irq,
  input  logic [3:0]            trap_cause,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic [DATA_WIDTH-1:0] trap_val,
  input  logic                  mret_req,
  input  logic [1:0]            current_privilege,
  output logic [CSR_WIDTH-1:0]  csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  csr_we,
  output logic                  csr_re,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  busy,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [1:0]            new_privilege
);

  localparam logic [CSR_WIDTH-1:0] ADDR_MSTATUS = CSR_WIDTH'(12'h300);
  localparam logic [CSR_WIDTH-1:0] ADDR_MTVEC   = CSR_WIDTH'(12'h305);
  localparam logic [CSR_WIDTH-1:0] ADDR_MEPC    = CSR_WIDTH'(12'h341);
  localparam logic [CSR_WIDTH-1:0] ADDR_MCAUSE  = CSR_WIDTH'(12'h342);
  localparam logic [CSR_WIDTH-1:0] ADDR_MTVAL   = CSR_WIDTH'(12'h343);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;

  typedef enum logic [3:0] {
    IDLE,
    T_RD_ST,
    T_WR_ST,
    T_WR_EPC,
    T_WR_CAUSE,
    T_WR_TVAL,
    T_RD_TVEC,
    M_RD_ST,
    M_WR_ST,
    M_RD_EPC,
    REDIR
  } state_t;

  state_t                state;
  logic                  irq_q;
  logic [3:0]            cause_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] val_q;
  logic [1:0]            priv_q;
  logic [1:0]            mpp_q;

  logic [DATA_WIDTH-1:0] trap_status_w;
  logic [DATA_WIDTH-1:0] mret_status_w;
  logic [DATA_WIDTH-1:0] epc_w;
  logic [DATA_WIDTH-1:0] cause_w;
  logic [DATA_WIDTH-1:0] tvec_base;
  logic [DATA_WIDTH-1:0] tvec_target;
  logic [DATA_WIDTH-1:0] mepc_target;

  // Write data is formed straight from csr_rdata so it can be registered in
  // the same cycle the read strobe is high.
  always_comb begin
    trap_status_w                = csr_rdata;
    trap_status_w[MPIE_BIT]      = csr_rdata[MIE_BIT];
    trap_status_w[MIE_BIT]       = 1'b0;
    trap_status_w[MPP_HI:MPP_LO] = priv_q;

    mret_status_w                = csr_rdata;
    mret_status_w[MIE_BIT]       = csr_rdata[MPIE_BIT];
    mret_status_w[MPIE_BIT]      = 1'b1;
    mret_status_w[MPP_HI:MPP_LO] = 2'b00;

    epc_w = pc_q & ALIGN_MASK;

    cause_w                 = '0;
    cause_w[DATA_WIDTH-1]   = irq_q;
    cause_w[3:0]            = cause_q;

    tvec_base = csr_rdata & ALIGN_MASK;
    if (csr_rdata[1:0] == 2'b01 && irq_q)
      tvec_target = tvec_base + {{(DATA_WIDTH-6){1'b0}}, cause_q, 2'b00};
    else
      tvec_target = tvec_base;

    mepc_target = csr_rdata & ALIGN_MASK;
  end

  // Each state's outputs are registered on the edge that enters it, so the
  // case arm below sets up the CSR operation of the following state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      csr_addr       <= '0;
      csr_wdata      <= '0;
      csr_we         <= 1'b0;
      csr_re         <= 1'b0;
      busy           <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      new_privilege  <= 2'b11;
      irq_q          <= 1'b0;
      cause_q        <= '0;
      pc_q           <= '0;
      val_q          <= '0;
      priv_q         <= '0;
      mpp_q          <= '0;
    end else begin
      csr_addr       <= '0;
      csr_wdata      <= '0;
      csr_we         <= 1'b0;
      csr_re         <= 1'b0;
      redirect_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (trap_req) begin
            irq_q    <= trap_is_irq;
            cause_q  <= trap_cause;
            pc_q     <= trap_pc;
            val_q    <= trap_val;
            priv_q   <= current_privilege;
            state    <= T_RD_ST;
            busy     <= 1'b1;
            csr_re   <= 1'b1;
            csr_addr <= ADDR_MSTATUS;
          end else if (mret_req) begin
            priv_q   <= current_privilege;
            state    <= M_RD_ST;
            busy     <= 1'b1;
            csr_re   <= 1'b1;
            csr_addr <= ADDR_MSTATUS;
          end
        end

        T_RD_ST: begin
          state     <= T_WR_ST;
          csr_we    <= 1'b1;
          csr_addr  <= ADDR_MSTATUS;
          csr_wdata <= trap_status_w;
        end

        T_WR_ST: begin
          state     <= T_WR_EPC;
          csr_we    <= 1'b1;
          csr_addr  <= ADDR_MEPC;
          csr_wdata <= epc_w;
        end

        T_WR_EPC: begin
          state     <= T_WR_CAUSE;
          csr_we    <= 1'b1;
          csr_addr  <= ADDR_MCAUSE;
          csr_wdata <= cause_w;
        end

        T_WR_CAUSE: begin
          state     <= T_WR_TVAL;
          csr_we    <= 1'b1;
          csr_addr  <= ADDR_MTVAL;
          csr_wdata <= val_q;
        end

        T_WR_TVAL: begin
          state    <= T_RD_TVEC;
          csr_re   <= 1'b1;
          csr_addr <= ADDR_MTVEC;
        end

        T_RD_TVEC: begin
          state          <= REDIR;
          redirect_valid <= 1'b1;
          redirect_pc    <= tvec_target;
          new_privilege  <= 2'b11;
        end

        M_RD_ST: begin
          mpp_q     <= csr_rdata[MPP_HI:MPP_LO];
          state     <= M_WR_ST;
          csr_we    <= 1'b1;
          csr_addr  <= ADDR_MSTATUS;
          csr_wdata <= mret_status_w;
        end

        M_WR_ST: begin
          state    <= M_RD_EPC;
          csr_re   <= 1'b1;
          csr_addr <= ADDR_MEPC;
        end

        M_RD_EPC: begin
          state          <= REDIR;
          redirect_valid <= 1'b1;
          redirect_pc    <= mepc_target;
          new_privilege  <= mpp_q;
        end

        REDIR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
